// File: rtl/aes_pkg.sv
// Shared AES/Rijndael helpers: mode and skid-state encodings, ShiftRows offsets
// and the column-major byte numbering used by every state-wide datapath.
package aes_pkg;

  localparam int ROWS = 4;

  typedef enum logic {
    MODE_FWD = 1'b0,
    MODE_INV = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  function automatic int state_width(input int nb);
    return 32 * nb;
  endfunction

  function automatic bit nb_legal(input int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  // Rijndael row offsets; the 256-bit block widens rows 2 and 3 by one column.
  function automatic int shift_amt(input int nb, input int row);
    case (row)
      0:       return 0;
      1:       return 1;
      2:       return (nb == 8) ? 3 : 2;
      default: return (nb == 8) ? 4 : 3;
    endcase
  endfunction

  // Byte (r,c) is the (4c+r)-th byte counted from the MSB end of the state.
  function automatic int byte_pos(input int row, input int col);
    return ROWS * col + row;
  endfunction

endpackage

// File: rtl/shift_rows_stream_if.sv
// Valid/ready beat carrying one Rijndael state plus its forward/inverse tag.
interface shift_rows_stream_if #(
  parameter int W = 128
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  logic         inv;

  modport master (output valid, data, inv, input  ready);
  modport slave  (input  valid, data, inv, output ready);
endinterface

// File: rtl/shift_rows_comb.sv
// Combinational ShiftRows / InvShiftRows byte permutation for Nb = 4, 6 or 8.
// Pure wiring plus one 2:1 mux per byte; shared with the unrolled pipeline.
module shift_rows_comb
  import aes_pkg::*;
#(
  parameter int NB       = 4,
  parameter bit FWD_ONLY = 1'b0
) (
  input  logic [32*NB-1:0] data_in,
  input  logic             inv,
  output logic [32*NB-1:0] data_out
);

  localparam int W = state_width(NB);

  if (!nb_legal(NB)) begin : g_illegal_nb
    $error("shift_rows_comb: NB=%0d unsupported, use 4, 6 or 8", NB);
  end

  logic sel_inv;
  assign sel_inv = inv & ~FWD_ONLY;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int SH      = shift_amt(NB, r);
      localparam int DST     = W - 8 - 8 * byte_pos(r, c);
      localparam int SRC_FWD = W - 8 - 8 * byte_pos(r, (c + SH) % NB);
      localparam int SRC_INV = W - 8 - 8 * byte_pos(r, (c + NB - SH) % NB);

      assign data_out[DST +: 8] = sel_inv ? data_in[SRC_INV +: 8]
                                          : data_in[SRC_FWD +: 8];
    end
  end

endmodule

// File: rtl/shift_rows_stream.sv
// Registered ShiftRows stream stage: main output register M plus one skid
// register S, so in_ready comes straight from a flop and never from out_ready.
module shift_rows_stream
  import aes_pkg::*;
#(
  parameter int NB       = 4,
  parameter bit FWD_ONLY = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  shift_rows_stream_if.slave  in_if,
  shift_rows_stream_if.master out_if,
  output logic                busy
);

  localparam int W = state_width(NB);

  skid_state_e  state_q, state_d;
  logic [W-1:0] shifted;
  logic [W-1:0] m_data_q, m_data_d;
  logic [W-1:0] s_data_q, s_data_d;
  mode_e        in_mode;
  mode_e        m_inv_q, m_inv_d;
  mode_e        s_inv_q, s_inv_d;
  logic         in_ready_q, in_ready_d;
  logic         in_xfer, out_xfer;

  shift_rows_comb #(
    .NB       (NB),
    .FWD_ONLY (FWD_ONLY)
  ) u_comb (
    .data_in  (in_if.data),
    .inv      (in_if.inv),
    .data_out (shifted)
  );

  assign in_mode = (FWD_ONLY || !in_if.inv) ? MODE_FWD : MODE_INV;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d  = state_q;
    m_data_d = m_data_q;
    m_inv_d  = m_inv_q;
    s_data_d = s_data_q;
    s_inv_d  = s_inv_q;
    out_xfer = (state_q != ST_EMPTY) && out_if.ready;
    in_xfer  = in_if.valid && in_ready_q;

    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          state_d  = ST_ONE;
          m_data_d = shifted;
          m_inv_d  = in_mode;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          m_data_d = shifted;
          m_inv_d  = in_mode;
        end else if (in_xfer) begin
          state_d  = ST_FULL;
          s_data_d = shifted;
          s_inv_d  = in_mode;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          state_d  = ST_ONE;
          m_data_d = s_data_q;
          m_inv_d  = s_inv_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    in_ready_d = (state_d != ST_FULL);
  end

  // in_ready is its own flop so it reads 0 throughout reset and rises on the
  // first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data registers are reset too, because out_data must read 0
      // after reset rather than whatever the last beat left behind.
      state_q    <= ST_EMPTY;
      m_data_q   <= '0;
      m_inv_q    <= MODE_FWD;
      s_data_q   <= '0;
      s_inv_q    <= MODE_FWD;
      in_ready_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q    <= state_d;
      m_data_q   <= m_data_d;
      m_inv_q    <= m_inv_d;
      s_data_q   <= s_data_d;
      s_inv_q    <= s_inv_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_if.ready  = in_ready_q;
  assign out_if.valid = (state_q != ST_EMPTY);
  assign out_if.data  = m_data_q;
  assign out_if.inv   = m_inv_q;
  assign busy         = (state_q != ST_EMPTY);

endmodule

// File: tb/tb_shift_rows_stream.sv
// Directed bench for shift_rows_stream: NB=4 stream with skid/backpressure,
// NB=8 offsets, NB=6 forward-only build and asynchronous reset while full.
module tb_shift_rows_stream;
  import aes_pkg::*;

  typedef struct {
    logic [127:0] data;
    logic         inv;
  } beat_t;

  localparam logic [127:0] VEC     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FWD_EXP = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [127:0] INV_EXP = 128'h000d0a0704010e0b0805020f0c090603;

  logic  clk;
  logic  rst;
  logic  busy4, busy8, busy6;
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    n_out4   = 0;
  bit    mon_en   = 1'b1;
  string mon_tag  = "idle";
  beat_t exp_q[$];

  shift_rows_stream_if #(.W(128)) if4i ();
  shift_rows_stream_if #(.W(128)) if4o ();
  shift_rows_stream_if #(.W(256)) if8i ();
  shift_rows_stream_if #(.W(256)) if8o ();
  shift_rows_stream_if #(.W(192)) if6i ();
  shift_rows_stream_if #(.W(192)) if6o ();

  shift_rows_stream #(.NB(4), .FWD_ONLY(1'b0)) u_dut4 (
    .clk (clk), .rst (rst), .in_if (if4i.slave), .out_if (if4o.master), .busy (busy4)
  );
  shift_rows_stream #(.NB(8), .FWD_ONLY(1'b0)) u_dut8 (
    .clk (clk), .rst (rst), .in_if (if8i.slave), .out_if (if8o.master), .busy (busy8)
  );
  shift_rows_stream #(.NB(6), .FWD_ONLY(1'b1)) u_dut6 (
    .clk (clk), .rst (rst), .in_if (if6i.slave), .out_if (if6o.master), .busy (busy6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference ShiftRows on the low 32*nb bits, byte (r,c) counted from the MSB.
  function automatic logic [255:0] ref_shift(input int nb, input logic [255:0] d, input bit inv);
    logic [7:0]   b [32];
    logic [255:0] r;
    int w, sh, src;
    w = 32 * nb;
    r = '0;
    for (int k = 0; k < 4 * nb; k++) b[k] = d[w-1-8*k -: 8];
    for (int c = 0; c < nb; c++) begin
      for (int row = 0; row < 4; row++) begin
        sh  = (row < 2) ? row : ((nb == 8) ? row + 1 : row);
        src = inv ? (c - sh + nb) % nb : (c + sh) % nb;
        r[w-1-8*(4*c+row) -: 8] = b[4*src+row];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] ref4(input logic [127:0] d, input bit inv);
    logic [255:0] t;
    t = ref_shift(4, {128'b0, d}, inv);
    return t[127:0];
  endfunction

  // Inputs change 2 time units after the rising edge; outputs are read there
  // or at the falling edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Presents one beat to the NB=4 stage, waits (bounded) for in_ready and
  // returns just after the accepting edge with valid still asserted.
  task automatic send4(input logic [127:0] d, input logic inv, input logic [127:0] exp_d);
    int n;
    if4i.valid = 1'b1;
    if4i.data  = d;
    if4i.inv   = inv;
    n = 0;
    while (!if4i.ready && n < 50) begin
      tick();
      n++;
    end
    if (!if4i.ready) begin
      check("send_timeout", 256'(if4i.ready), 256'(1));
      if4i.valid = 1'b0;
    end else begin
      tick();
      exp_q.push_back('{data: exp_d, inv: inv});
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("drain_empty", 256'(exp_q.size()), 256'(0));
  endtask

  always @(negedge clk) begin : mon4
    beat_t e;
    if (!rst && mon_en && if4o.valid && if4o.ready) begin
      n_out4 <= n_out4 + 1;
      if (exp_q.size() == 0) begin
        check({mon_tag, "_extra_beat"}, 256'(1), 256'(0));
      end else begin
        e = exp_q.pop_front();
        check({mon_tag, "_data"}, 256'(if4o.data), 256'(e.data));
        check({mon_tag, "_inv"}, 256'(if4o.inv), 256'(e.inv));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic [127:0] v, r1, b1, b2, b3, d;
    logic [255:0] v8, o8;
    logic [191:0] v6;
    logic         a;
    int           c0, n0;

    rst = 1'b1;
    if4i.valid = 1'b0; if4i.data = '0; if4i.inv = 1'b0; if4o.ready = 1'b0;
    if8i.valid = 1'b0; if8i.data = '0; if8i.inv = 1'b0; if8o.ready = 1'b0;
    if6i.valid = 1'b0; if6i.data = '0; if6i.inv = 1'b0; if6o.ready = 1'b0;

    // Reset state
    tick();
    check("rst_out_valid", 256'(if4o.valid), 256'(0));
    check("rst_busy", 256'(busy4), 256'(0));
    check("rst_out_data", 256'(if4o.data), 256'(0));
    check("rst_out_inv", 256'(if4o.inv), 256'(0));
    check("rst_in_ready", 256'(if4i.ready), 256'(0));
    tick();
    rst = 1'b0;
    tick();
    check("in_ready_after_rst", 256'(if4i.ready), 256'(1));
    check("in_ready8_after_rst", 256'(if8i.ready), 256'(1));

    // NB=4 forward, one-cycle latency
    if4o.ready = 1'b1;
    mon_tag = "fwd4";
    send4(VEC, 1'b0, FWD_EXP);
    if4i.valid = 1'b0;
    check("fwd4_latency_valid", 256'(if4o.valid), 256'(1));
    check("fwd4_direct_data", 256'(if4o.data), 256'(FWD_EXP));
    tick();
    check("fwd4_empty_after", 256'(if4o.valid), 256'(0));

    // NB=4 inverse
    mon_tag = "inv4";
    send4(VEC, 1'b1, INV_EXP);
    if4i.valid = 1'b0;
    check("inv4_direct_data", 256'(if4o.data), 256'(INV_EXP));
    tick();

    // Round trip through the DUT in both orders
    mon_en = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      a = i[0];
      if4i.valid = 1'b1; if4i.data = v; if4i.inv = a;
      tick();
      if4i.valid = 1'b0;
      r1 = if4o.data;
      check("rt_leg1", 256'(r1), 256'(ref4(v, a)));
      if4i.valid = 1'b1; if4i.data = r1; if4i.inv = ~a;
      tick();
      if4i.valid = 1'b0;
      check("rt_leg2", 256'(if4o.data), 256'(v));
    end
    tick();
    mon_en = 1'b1;

    // NB=8 forward on byte i = i, then inverse
    for (int k = 0; k < 32; k++) v8[255-8*k -: 8] = k[7:0];
    if8o.ready = 1'b1;
    if8i.valid = 1'b1; if8i.data = v8; if8i.inv = 1'b0;
    tick();
    if8i.valid = 1'b0;
    o8 = if8o.data;
    check("nb8_valid", 256'(if8o.valid), 256'(1));
    check("nb8_fwd", o8, ref_shift(8, v8, 1'b0));
    check("nb8_r2c0", 256'(o8[239:232]), 256'(8'h0e));
    check("nb8_r3c0", 256'(o8[231:224]), 256'(8'h13));
    check("nb8_fwd_tag", 256'(if8o.inv), 256'(0));
    if8i.valid = 1'b1; if8i.inv = 1'b1;
    tick();
    if8i.valid = 1'b0;
    check("nb8_inv", if8o.data, ref_shift(8, v8, 1'b1));
    check("nb8_inv_tag", 256'(if8o.inv), 256'(1));
    tick();

    // NB=6 forward-only build ignores in_inv
    v6 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    if6o.ready = 1'b1;
    if6i.valid = 1'b1; if6i.data = v6; if6i.inv = 1'b1;
    tick();
    if6i.valid = 1'b0;
    check("nb6_fwdonly_data", 256'(if6o.data), ref_shift(6, {64'b0, v6}, 1'b0));
    check("nb6_fwdonly_tag", 256'(if6o.inv), 256'(0));
    tick();

    // Backpressure: two beats fill M and S, the third stalls
    mon_tag = "bp";
    if4o.ready = 1'b0;
    b1 = 128'h11111111_22222222_33333333_44444444;
    b2 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    b3 = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    send4(b1, 1'b0, ref4(b1, 1'b0));
    send4(b2, 1'b1, ref4(b2, 1'b1));
    if4i.valid = 1'b1; if4i.data = b3; if4i.inv = 1'b0;
    check("bp_in_ready_low", 256'(if4i.ready), 256'(0));
    check("bp_busy", 256'(busy4), 256'(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_valid", 256'(if4o.valid), 256'(1));
      check("bp_hold_data", 256'(if4o.data), 256'(ref4(b1, 1'b0)));
      check("bp_hold_inv", 256'(if4o.inv), 256'(0));
      check("bp_stall_ready", 256'(if4i.ready), 256'(0));
    end
    n0 = n_out4;
    if4o.ready = 1'b1;
    send4(b3, 1'b0, ref4(b3, 1'b0));
    if4i.valid = 1'b0;
    drain();
    tick();
    check("bp_beat_count", 256'(n_out4 - n0), 256'(3));

    // Alternating mode at full rate
    mon_tag = "alt";
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      a = i[0];
      send4(d, a, ref4(d, a));
    end
    if4i.valid = 1'b0;
    check("alt_rate_cycles", 256'(cyc - c0), 256'(8));
    drain();

    // Asynchronous reset while FULL
    mon_tag = "rst";
    if4o.ready = 1'b0;
    send4(b1, 1'b1, ref4(b1, 1'b1));
    send4(b2, 1'b0, ref4(b2, 1'b0));
    if4i.valid = 1'b0;
    check("full_before_rst", 256'(if4i.ready), 256'(0));
    rst = 1'b1;
    #1;
    check("async_rst_valid", 256'(if4o.valid), 256'(0));
    check("async_rst_busy", 256'(busy4), 256'(0));
    check("async_rst_data", 256'(if4o.data), 256'(0));
    check("async_rst_inv", 256'(if4o.inv), 256'(0));
    check("async_rst_ready", 256'(if4i.ready), 256'(0));
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", 256'(if4i.ready), 256'(1));
    check("post_rst_valid", 256'(if4o.valid), 256'(0));
    n0 = n_out4;
    if4o.ready = 1'b1;
    send4(b3, 1'b1, ref4(b3, 1'b1));
    if4i.valid = 1'b0;
    drain();
    tick();
    check("post_rst_beat_count", 256'(n_out4 - n0), 256'(1));
    check("post_rst_idle", 256'(if4o.valid), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
